time_preset_loader: RTL and testbench

//  Parametrised, validated time-preset path for the real-time clock. Samples BCD

---
 rtl/rtc_pkg.sv | 20 ++
 rtl/sync_rise_detect.sv | 38 +++
 rtl/time_preset_loader.sv | 115 +++++++++++
 tb/tb_time_preset_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared constants and state type for the real-time clock preset path.
package rtc_pkg;

  localparam int unsigned BCD_W = 4;

  localparam logic [BCD_W-1:0] UNITS_MAX          = 4'd9;
  localparam logic [BCD_W-1:0] SEC_TENS_MAX       = 4'd5;
  localparam logic [BCD_W-1:0] MIN_TENS_MAX       = 4'd5;
  localparam logic [BCD_W-1:0] HR_TENS_MAX        = 4'd2;
  localparam logic [BCD_W-1:0] HR_UNITS_MAX_AT_20 = 4'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_CHECK,
    ST_OFFER,
    ST_ERROR
  } loader_state_t;

endpackage

// File: rtl/sync_rise_detect.sv
// Synchroniser for a raw button plus a registered one-cycle rising-edge pulse.
module sync_rise_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   level;
  logic                   level_d1;
  logic                   armed_q;

  assign level = sync_q[SYNC_STAGES-1];

  // Arming waits until the chain holds real samples and shows a low level, so a
  // button held through reset cannot fake an edge when the chain refills.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q   <= '0;
      fill_q   <= '0;
      level_d1 <= 1'b0;
      armed_q  <= 1'b0;
      rise     <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], async_in};
      fill_q   <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      level_d1 <= level;
      if (fill_q[SYNC_STAGES-1] && !level)
        armed_q <= 1'b1;
      rise     <= armed_q & level & ~level_d1;
    end
  end

endmodule

// File: rtl/time_preset_loader.sv
// Captures BCD switch digits on a button press, range-checks them and offers the
// accepted preset to the time counter over a valid/ready handshake.
module time_preset_loader
  import rtc_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [BCD_W*NUM_DIGITS-1:0]   switches,
  input  logic                          load_request,
  input  logic                          load_ready,
  output logic [BCD_W*NUM_DIGITS-1:0]   digits,
  output logic                          load_valid,
  output logic                          error_flag,
  output logic                          busy
);

  localparam int unsigned W = BCD_W * NUM_DIGITS;

  if (!((NUM_DIGITS == 4 || NUM_DIGITS == 6) && SYNC_STAGES >= 2)) begin : g_param_check
    $error("time_preset_loader: NUM_DIGITS must be 4 or 6 and SYNC_STAGES >= 2");
  end

  loader_state_t  state_q, state_d;
  logic [W-1:0]   shadow_q, shadow_d;
  logic [W-1:0]   digits_q, digits_d;
  logic           error_q, error_d;
  logic           rise;

  sync_rise_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_load_rise (
    .clock    (clock),
    .reset    (reset),
    .async_in (load_request),
    .rise     (rise)
  );

  // Nibble i = 0 is seconds units; hour tens of 2 caps hour units at 3.
  function automatic logic preset_ok(input logic [W-1:0] v);
    logic              ok;
    logic [BCD_W-1:0]  nib;
    logic [BCD_W-1:0]  lim;
    ok = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      nib = v[i*BCD_W +: BCD_W];
      case (i)
        1:       lim = SEC_TENS_MAX;
        3:       lim = MIN_TENS_MAX;
        5:       lim = HR_TENS_MAX;
        default: lim = UNITS_MAX;
      endcase
      if (nib > lim)
        ok = 1'b0;
      if (i == 5 && nib == HR_TENS_MAX && v[(i-1)*BCD_W +: BCD_W] > HR_UNITS_MAX_AT_20)
        ok = 1'b0;
    end
    return ok;
  endfunction

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    digits_d = digits_q;
    error_d  = error_q;
    unique case (state_q)
      ST_IDLE:    if (rise) state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        shadow_d = switches;
        state_d  = ST_CHECK;
      end
      ST_CHECK: begin
        if (preset_ok(shadow_q)) begin
          digits_d = shadow_q;
          state_d  = ST_OFFER;
        end else begin
          state_d  = ST_ERROR;
        end
      end
      ST_OFFER: begin
        if (load_ready) begin
          error_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_ERROR: begin
        error_d = 1'b1;
        state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      digits_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      digits_q <= digits_d;
      error_q  <= error_d;
    end
  end

  assign digits     = digits_q;
  assign error_flag = error_q;
  assign load_valid = (state_q == ST_OFFER);
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_time_preset_loader.sv
// Randomised and directed check of the preset loader in mm:ss and hh:mm:ss builds.
module tb_time_preset_loader;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_request = 1'b0;
  logic        load_ready = 1'b0;
  logic [15:0] sw4 = '0;
  logic [23:0] sw6 = '0;
  logic [15:0] dg4;
  logic [23:0] dg6;
  logic        v4, v6, e4, e6, b4, b6;

  logic [15:0] expd4 = '0;
  logic [23:0] expd6 = '0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  time_preset_loader #(.NUM_DIGITS(4), .SYNC_STAGES(SYNC)) u_dut4 (
    .clock(clk), .reset(reset), .switches(sw4), .load_request(load_request),
    .load_ready(load_ready), .digits(dg4), .load_valid(v4), .error_flag(e4), .busy(b4)
  );

  time_preset_loader #(.NUM_DIGITS(6), .SYNC_STAGES(SYNC)) u_dut6 (
    .clock(clk), .reset(reset), .switches(sw6), .load_request(load_request),
    .load_ready(load_ready), .digits(dg6), .load_valid(v6), .error_flag(e6), .busy(b6)
  );

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: legal iff every digit is decimal and the fields are real clock values.
  function automatic bit legal4(input logic [15:0] v);
    int d[4];
    for (int i = 0; i < 4; i++) begin
      d[i] = int'(v[i*4 +: 4]);
      if (d[i] > 9) return 1'b0;
    end
    return (d[0] + 10*d[1] < 60) && (d[2] + 10*d[3] < 60);
  endfunction

  function automatic bit legal6(input logic [23:0] v);
    int d[6];
    for (int i = 0; i < 6; i++) begin
      d[i] = int'(v[i*4 +: 4]);
      if (d[i] > 9) return 1'b0;
    end
    return (d[0] + 10*d[1] < 60) && (d[2] + 10*d[3] < 60) && (d[4] + 10*d[5] < 24);
  endfunction

  function automatic logic [3:0] rnib();
    logic [3:0] n;
    if ($urandom_range(0, 3) != 0) n = 4'($urandom_range(0, 9));
    else                           n = 4'($urandom_range(0, 15));
    return n;
  endfunction

  task automatic press(input logic [15:0] s4, input logic [23:0] s6,
                       input int delay, input bit repress);
    bit ok4, ok6, extra;
    int n, vc4, vc6, first4, first6, want_vc;
    ok4 = legal4(s4);
    ok6 = legal6(s6);
    sw4 = s4;
    sw6 = s6;
    load_ready = (delay == 0);
    load_request = 1'b1;
    n = 0;
    while (!b4 && n < 12) begin
      step();
      n++;
    end
    check_eq("press_to_busy", n, SYNC + 2);
    vc4 = 0; vc6 = 0; first4 = -1; first6 = -1;
    for (int t = 1; t <= 40; t++) begin
      step();
      if (t == delay) load_ready = 1'b1;
      if (repress && t == 1) load_request = 1'b0;
      if (repress && t == 4) load_request = 1'b1;
      if (v4) begin
        if (first4 < 0) first4 = t;
        check_eq("offer_digits4", dg4, s4);
        if (load_ready) vc4++;
      end
      if (v6) begin
        if (first6 < 0) first6 = t;
        check_eq("offer_digits6", dg6, s6);
        if (load_ready) vc6++;
      end
      if (!b4 && !b6) break;
    end
    if (ok4) expd4 = s4;
    if (ok6) expd6 = s6;
    want_vc = 1;
    check_eq("valid_latency4", first4, ok4 ? 2 : -1);
    check_eq("valid_latency6", first6, ok6 ? 2 : -1);
    check_eq("transfers4", vc4, ok4 ? want_vc : 0);
    check_eq("transfers6", vc6, ok6 ? want_vc : 0);
    check_eq("error_flag4", e4, !ok4);
    check_eq("error_flag6", e6, !ok6);
    check_eq("digits4", dg4, expd4);
    check_eq("digits6", dg6, expd6);
    check_eq("busy_after4", b4, 0);
    check_eq("busy_after6", b6, 0);
    load_request = 1'b0;
    load_ready = 1'b0;
    extra = 1'b0;
    for (int t = 0; t < 6; t++) begin
      step();
      extra |= b4 | b6;
    end
    check_eq("no_extra_load", extra, 0);
  endtask

  task automatic hold_check(input int cycles);
    int vcount;
    bit stable;
    vcount = 0;
    stable = 1'b1;
    for (int t = 0; t < cycles; t++) begin
      step();
      if (v4) vcount++;
      if (dg4 != 16'h0912) stable = 1'b0;
    end
    check_eq("stall_valid_held", vcount, cycles);
    check_eq("stall_digits_stable", stable, 1);
  endtask

  initial begin
    bit seen, busy_seen;
    int n;
    repeat (3) step();
    reset = 1'b0;
    check_eq("rst_valid4", v4, 0);
    check_eq("rst_valid6", v6, 0);
    check_eq("rst_digits4", dg4, 0);
    check_eq("rst_digits6", dg6, 0);
    check_eq("rst_err4", e4, 0);
    check_eq("rst_err6", e6, 0);
    check_eq("rst_busy4", b4, 0);
    check_eq("rst_busy6", b6, 0);
    repeat (10) step();

    press(16'h5959, 24'h235959, 0, 1'b0);
    press(16'h6000, 24'h240000, 0, 1'b0);
    press(16'h1234, 24'h300000, 0, 1'b0);
    press(16'h000A, 24'h00000A, 0, 1'b0);
    press(16'hFFFF, 24'hFFFFFF, 0, 1'b0);
    press(16'h0102, 24'h195959, 0, 1'b0);

    // Long stall in OFFER with a second press that must be dropped.
    sw4 = 16'h0912;
    sw6 = 24'h200912;
    load_ready = 1'b0;
    load_request = 1'b1;
    n = 0;
    while (!v4 && n < 20) begin
      step();
      n++;
    end
    load_request = 1'b0;
    hold_check(4);
    load_request = 1'b1;
    hold_check(6);
    load_ready = 1'b1;
    step();
    check_eq("stall_busy_after", b4, 0);
    check_eq("stall_digits4", dg4, 16'h0912);
    check_eq("stall_digits6", dg6, 24'h200912);
    expd4 = 16'h0912;
    expd6 = 24'h200912;
    load_ready = 1'b0;
    load_request = 1'b0;
    busy_seen = 1'b0;
    for (int t = 0; t < 10; t++) begin
      step();
      busy_seen |= b4 | b6;
    end
    check_eq("stall_no_second_load", busy_seen, 0);

    press(16'h3210, 24'h103210, 10, 1'b1);

    for (int k = 0; k < 20; k++) begin
      logic [15:0] r4;
      logic [23:0] r6;
      r4 = {rnib(), rnib(), rnib(), rnib()};
      r6 = {rnib(), rnib(), rnib(), rnib(), rnib(), rnib()};
      press(r4, r6, $urandom_range(0, 4), 1'b0);
    end

    // Reset while offering, button held through and after reset.
    sw4 = 16'h4321;
    sw6 = 24'h214321;
    load_ready = 1'b0;
    load_request = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      step();
      seen = v4 & v6;
    end
    check_eq("reset_offer_reached", seen, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("abort_valid4", v4, 0);
    check_eq("abort_valid6", v6, 0);
    check_eq("abort_digits4", dg4, 0);
    check_eq("abort_digits6", dg6, 0);
    check_eq("abort_busy4", b4, 0);
    check_eq("abort_busy6", b6, 0);
    expd4 = '0;
    expd6 = '0;
    busy_seen = 1'b0;
    for (int t = 0; t < 15; t++) begin
      step();
      busy_seen |= b4 | b6;
    end
    check_eq("held_no_load", busy_seen, 0);
    load_request = 1'b0;
    repeat (5) step();
    press(16'h0030, 24'h000030, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
